ghost_mover: RTL and testbench
==============================

GHOST_MOVER -- requirements
Module: ghost_mover

Parameters
REQ-001 The block SHALL accept parameter START_X, default 10'd320, as the reset X pixel position.
REQ-002 The block SHALL accept parameter START_Y, default 10'd240, as the reset Y pixel position.
REQ-003 The block SHALL accept parameter STEP, default 2, as the pixels moved per accepted frame tick.
REQ-004 The block SHALL accept parameter X_MAX, default 639, as the last valid X pixel; horizontal moves wrap at this value.
REQ-005 The block SHALL accept parameter Y_MAX, default 479, as the last valid Y pixel.
REQ-006 The block SHALL accept parameter SIZE, default 16, as the ghost sprite edge length in pixels.
REQ-007 The block SHALL accept parameter TILE_SHIFT, default 4, as log2 of the tile size in pixels.

Interface
REQ-008 Clk, input, 1: the single clock; all state is clocked on the rising edge.
REQ-009 Reset_n, input, 1: asynchronous, active-low reset.
REQ-010 frame_tick, input, 1: one-cycle pulse that requests one movement step.
REQ-011 dir_in, input, 8: direction keycode from the random-direction stage (0x04 left, 0x07 right, 0x16 down, 0x1A up).
REQ-012 query_valid, output, 1: wall-lookup request valid.
REQ-013 query_tx, output, 6: tile X of the candidate leading edge.
REQ-014 query_ty, output, 6: tile Y of the candidate leading edge.
REQ-015 wall_ready, input, 1: the wall map accepts the query; the transfer occurs in a cycle where query_valid and wall_ready are both 1.
REQ-016 wall_hit, input, 1: the queried tile is a wall; it is sampled only in the transfer cycle.
REQ-017 ghost_x, output, 10: current X pixel position.
REQ-018 ghost_y, output, 10: current Y pixel position.
REQ-019 cur_dir, output, 2: committed direction (00 left, 01 right, 10 down, 11 up).
REQ-020 step_done, output, 1: one-cycle pulse when a step evaluation completes, whether or not the ghost moved.
REQ-021 overrun, output, 1: sticky flag, set when a frame_tick arrives while the block is busy.

Function
REQ-022 The FSM SHALL have states IDLE, REQ_NEW, REQ_OLD, DONE.
REQ-023 IDLE with frame_tick=1 SHALL do the following:
- Decode dir_in into the trial direction; an unrecognised keycode uses cur_dir.
- Compute the candidate position.
- Go to REQ_NEW.
REQ-024 Candidate X SHALL be ghost_x-STEP for left and ghost_x+STEP for right; the arithmetic is 11-bit to capture over/underflow.
REQ-025 Left wrap: if ghost_x < STEP, the candidate SHALL be X_MAX+1-STEP+ghost_x.
REQ-026 Right wrap: if ghost_x+STEP > X_MAX, the candidate SHALL be ghost_x+STEP-(X_MAX+1).
REQ-027 Vertical moves SHALL NOT wrap.
- Up with ghost_y < STEP is treated as blocked with no query issued.
- Down with ghost_y+STEP+SIZE-1 > Y_MAX is treated as blocked with no query issued.
REQ-028 The leading edge SHALL be the candidate coordinate plus SIZE-1 for right/down and the candidate itself for left/up; query_tx/ty = leading edge >> TILE_SHIFT (the other axis uses the current coordinate).
REQ-029 In REQ_NEW, query_valid SHALL be 1 and query_tx/ty SHALL be held stable until the transfer.
REQ-030 On a REQ_NEW transfer with wall_hit=0, the block SHALL commit the position and the trial direction to cur_dir, then go to DONE.
REQ-031 On a REQ_NEW transfer with wall_hit=1 (or a pre-blocked move), the block SHALL do the following:
- If the trial direction equals cur_dir, go to DONE unmoved.
- Otherwise recompute the candidate using cur_dir and go to REQ_OLD.
REQ-032 REQ_OLD SHALL behave as REQ_NEW, except that a hit or pre-block goes to DONE unmoved with cur_dir unchanged.
REQ-033 DONE SHALL pulse step_done for one cycle and then return to IDLE.
REQ-034 Minimum latency SHALL be as follows:
- frame_tick at cycle N gives query_valid at N+1.
- With wall_ready=1 at N+1, ghost_x/ghost_y update and step_done=1 at N+2.
REQ-035 query_valid SHALL be 0 in IDLE and DONE and in the cycle after any transfer.
REQ-036 A frame_tick outside IDLE SHALL be ignored and SHALL set overrun; once set, overrun is cleared only by reset.

Reset
REQ-037 While Reset_n=0 the outputs SHALL hold these values:
- ghost_x=START_X, ghost_y=START_Y, cur_dir=00.
- query_valid=0, step_done=0, overrun=0.
- The FSM is in IDLE.
REQ-038 Reset asserted mid-query SHALL abort the step immediately, with no position commit and query_valid low asynchronously.

Verification
REQ-039 Reset, then frame_tick with dir_in=0x07, wall_ready=1, wall_hit=0 -> at tick+2: ghost_x=322, ghost_y=240, cur_dir=01, step_done=1.
REQ-040 ghost_x=0, dir_in=0x04, no wall -> ghost_x=638; query_tx=39.
REQ-041 cur_dir=01, dir_in=0x1A, first query wall_hit=1, second query wall_hit=0 -> two transfers, ghost_x+=2, cur_dir stays 01.
REQ-042 wall_ready held 0 for 5 cycles -> query_valid and query_tx/ty stay stable; a frame_tick during this wait sets overrun and causes no second step.
REQ-043 ghost_y=0, dir_in=0x1A, cur_dir=00, left tile wall_hit=1 -> first query suppressed, one query for left, step_done with no movement.
REQ-044 Reset_n pulsed low while query_valid=1 -> ghost_x/ghost_y return to START values, and the next frame_tick starts a fresh step.

Source files
------------

// File: rtl/ghost_mover.sv
// Ghost movement controller: turns a frame tick plus a direction keycode into one
// wall-checked step, retrying along the committed direction when the new one is blocked.
//
// state   | meaning
// IDLE    | waiting for frame_tick
// REQ_NEW | querying the wall map for the trial direction
// REQ_OLD | querying the wall map for the committed direction
// DONE    | step evaluated, step_done pulses
module ghost_mover #(
    parameter logic [9:0] START_X    = 10'd320,
    parameter logic [9:0] START_Y    = 10'd240,
    parameter int         STEP       = 2,
    parameter int         X_MAX      = 639,
    parameter int         Y_MAX      = 479,
    parameter int         SIZE       = 16,
    parameter int         TILE_SHIFT = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] dir_in,
    output logic       query_valid,
    output logic [5:0] query_tx,
    output logic [5:0] query_ty,
    input  logic       wall_ready,
    input  logic       wall_hit,
    output logic [9:0] ghost_x,
    output logic [9:0] ghost_y,
    output logic [1:0] cur_dir,
    output logic       step_done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, REQ_NEW, REQ_OLD, DONE} state_t;

    typedef struct packed {
        logic       blocked;
        logic [9:0] nx;
        logic [9:0] ny;
        logic [5:0] tx;
        logic [5:0] ty;
    } cand_t;

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] XMAX_W  = 11'(X_MAX);
    localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
    localparam logic [10:0] SIZE_M1 = 11'(SIZE - 1);

    function automatic logic [1:0] decode_dir(input logic [7:0] code, input logic [1:0] fallback);
        logic [1:0] d;
        case (code)
            8'h04:   d = 2'b00;
            8'h07:   d = 2'b01;
            8'h16:   d = 2'b10;
            8'h1A:   d = 2'b11;
            default: d = fallback;
        endcase
        return d;
    endfunction

    // Horizontal moves wrap around the screen; vertical moves that would leave it are blocked.
    function automatic cand_t candidate(input logic [1:0] d, input logic [9:0] x, input logic [9:0] y);
        cand_t       c;
        logic [10:0] x11, y11, cx, cy, ex, ey;
        x11       = {1'b0, x};
        y11       = {1'b0, y};
        cx        = x11;
        cy        = y11;
        ex        = x11;
        ey        = y11;
        c.blocked = 1'b0;
        case (d)
            2'b00: begin
                cx = (x11 < STEP_W) ? XMAX_W + 11'd1 - STEP_W + x11 : x11 - STEP_W;
                ex = cx;
            end
            2'b01: begin
                cx = x11 + STEP_W;
                if (cx > XMAX_W) cx = cx - (XMAX_W + 11'd1);
                ex = cx + SIZE_M1;
            end
            2'b10: begin
                c.blocked = (y11 + STEP_W + SIZE_M1) > YMAX_W;
                cy        = y11 + STEP_W;
                ey        = cy + SIZE_M1;
            end
            default: begin
                c.blocked = y11 < STEP_W;
                cy        = y11 - STEP_W;
                ey        = cy;
            end
        endcase
        c.nx = cx[9:0];
        c.ny = cy[9:0];
        c.tx = 6'(ex >> TILE_SHIFT);
        c.ty = 6'(ey >> TILE_SHIFT);
        return c;
    endfunction

    state_t     state, state_nxt;
    logic [1:0] trial_dir, trial_dir_nxt, cur_dir_nxt, trial_in;
    logic [9:0] cand_x, cand_x_nxt, cand_y, cand_y_nxt;
    logic [9:0] ghost_x_nxt, ghost_y_nxt;
    logic [5:0] q_tx_nxt, q_ty_nxt;
    logic       gap, gap_nxt, overrun_nxt, xfer;
    cand_t      c_trial, c_cur;

    // gap keeps query_valid low for the cycle after a REQ_NEW transfer that falls back to REQ_OLD
    assign query_valid = (state == REQ_NEW || state == REQ_OLD) && !gap;
    assign step_done   = (state == DONE);
    assign xfer        = query_valid && wall_ready;

    always_comb begin
        state_nxt     = state;
        trial_dir_nxt = trial_dir;
        cur_dir_nxt   = cur_dir;
        cand_x_nxt    = cand_x;
        cand_y_nxt    = cand_y;
        ghost_x_nxt   = ghost_x;
        ghost_y_nxt   = ghost_y;
        q_tx_nxt      = query_tx;
        q_ty_nxt      = query_ty;
        gap_nxt       = 1'b0;
        overrun_nxt   = overrun | (frame_tick && state != IDLE);
        trial_in      = decode_dir(dir_in, cur_dir);
        c_trial       = candidate(trial_in, ghost_x, ghost_y);
        c_cur         = candidate(cur_dir, ghost_x, ghost_y);

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    trial_dir_nxt = trial_in;
                    if (!c_trial.blocked) begin
                        cand_x_nxt = c_trial.nx;
                        cand_y_nxt = c_trial.ny;
                        q_tx_nxt   = c_trial.tx;
                        q_ty_nxt   = c_trial.ty;
                        state_nxt  = REQ_NEW;
                    end else if (trial_in == cur_dir || c_cur.blocked) begin
                        state_nxt = DONE;
                    end else begin
                        cand_x_nxt = c_cur.nx;
                        cand_y_nxt = c_cur.ny;
                        q_tx_nxt   = c_cur.tx;
                        q_ty_nxt   = c_cur.ty;
                        state_nxt  = REQ_OLD;
                    end
                end
            end
            REQ_NEW: begin
                if (xfer) begin
                    if (!wall_hit) begin
                        ghost_x_nxt = cand_x;
                        ghost_y_nxt = cand_y;
                        cur_dir_nxt = trial_dir;
                        state_nxt   = DONE;
                    end else if (trial_dir == cur_dir || c_cur.blocked) begin
                        state_nxt = DONE;
                    end else begin
                        cand_x_nxt = c_cur.nx;
                        cand_y_nxt = c_cur.ny;
                        q_tx_nxt   = c_cur.tx;
                        q_ty_nxt   = c_cur.ty;
                        gap_nxt    = 1'b1;
                        state_nxt  = REQ_OLD;
                    end
                end
            end
            REQ_OLD: begin
                if (xfer) begin
                    if (!wall_hit) begin
                        ghost_x_nxt = cand_x;
                        ghost_y_nxt = cand_y;
                    end
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            trial_dir <= 2'b00;
            cur_dir   <= 2'b00;
            cand_x    <= START_X;
            cand_y    <= START_Y;
            ghost_x   <= START_X;
            ghost_y   <= START_Y;
            query_tx  <= 6'd0;
            query_ty  <= 6'd0;
            gap       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            trial_dir <= trial_dir_nxt;
            cur_dir   <= cur_dir_nxt;
            cand_x    <= cand_x_nxt;
            cand_y    <= cand_y_nxt;
            ghost_x   <= ghost_x_nxt;
            ghost_y   <= ghost_y_nxt;
            query_tx  <= q_tx_nxt;
            query_ty  <= q_ty_nxt;
            gap       <= gap_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: directed boundary steps plus a random walk, checked against
// a step-level model of the ghost position, direction and wall queries.
module tb_ghost_mover;

    localparam int STEP  = 2;
    localparam int W     = 640;
    localparam int Y_MAX = 479;
    localparam int SIZE  = 16;
    localparam int TILE  = 16;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] dir_in = 8'h00;
    logic       wall_ready = 1'b0;
    logic       wall_hit = 1'b0;
    logic       query_valid;
    logic [5:0] query_tx, query_ty;
    logic [9:0] ghost_x, ghost_y;
    logic [1:0] cur_dir;
    logic       step_done, overrun;

    int total = 0;
    int bad   = 0;
    int m_x, m_y, m_dir;

    ghost_mover dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .dir_in(dir_in),
        .query_valid(query_valid), .query_tx(query_tx), .query_ty(query_ty),
        .wall_ready(wall_ready), .wall_hit(wall_hit),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .cur_dir(cur_dir),
        .step_done(step_done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] code, input int fallback);
        case (code)
            8'h04:   return 0;
            8'h07:   return 1;
            8'h16:   return 2;
            8'h1A:   return 3;
            default: return fallback;
        endcase
    endfunction

    function automatic void cand(input int d, input int x, input int y, output bit blk,
                                 output int nx, output int ny, output int tx, output int ty);
        blk = 0;
        nx  = x;
        ny  = y;
        case (d)
            0: nx = (x - STEP + W) % W;
            1: nx = (x + STEP) % W;
            2: begin ny = y + STEP; blk = (ny + SIZE - 1 > Y_MAX); end
            default: begin ny = y - STEP; blk = (y < STEP); end
        endcase
        tx = ((d == 1) ? nx + SIZE - 1 : nx) / TILE;
        ty = ((d == 2) ? ny + SIZE - 1 : ny) / TILE;
    endfunction

    task automatic model_reset();
        m_x   = 320;
        m_y   = 240;
        m_dir = 0;
    endtask

    // One complete step: model first, then drive the tick and act as the wall map.
    task automatic do_step(input logic [7:0] code, input bit h0, input bit h1, input bit rnd_ready,
                           output int lat);
        int trial, nx, ny, tx, ty, ntr, k;
        bit blk, moved, seen, prev_xfer;
        bit hk[2];
        int etx[$], ety[$], rtx[$], rty[$];
        hk[0] = h0;
        hk[1] = h1;
        k     = 0;
        moved = 0;
        trial = decode(code, m_dir);
        cand(trial, m_x, m_y, blk, nx, ny, tx, ty);
        if (!blk) begin
            etx.push_back(tx); ety.push_back(ty);
            if (!hk[k]) begin m_x = nx; m_y = ny; m_dir = trial; moved = 1; end
            k++;
        end
        if (!moved && trial != m_dir) begin
            cand(m_dir, m_x, m_y, blk, nx, ny, tx, ty);
            if (!blk) begin
                etx.push_back(tx); ety.push_back(ty);
                if (!hk[k]) begin m_x = nx; m_y = ny; end
            end
        end

        frame_tick = 1'b1;
        dir_in     = code;
        wall_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        wall_hit   = 1'($urandom_range(0, 1));
        @(negedge Clk);
        frame_tick = 1'b0;
        dir_in     = 8'($urandom);
        seen = 0; ntr = 0; prev_xfer = 0; lat = -1;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            if (step_done === 1'b1) begin
                seen = 1;
                lat  = cyc;
            end else begin
                if (prev_xfer) chk("qv_after_xfer", 32'(query_valid), 32'd0);
                prev_xfer  = 0;
                wall_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (query_valid === 1'b1 && wall_ready) begin
                    rtx.push_back(int'(query_tx));
                    rty.push_back(int'(query_ty));
                    wall_hit  = (ntr < 2) ? hk[ntr] : 1'b1;
                    ntr++;
                    prev_xfer = 1;
                end else begin
                    wall_hit = 1'($urandom_range(0, 1));
                end
                @(negedge Clk);
            end
        end
        chk("step_done_seen", 32'(seen), 32'd1);
        chk("n_transfers", 32'(ntr), 32'(etx.size()));
        for (int i = 0; i < etx.size() && i < rtx.size(); i++) begin
            chk("query_tx", 32'(rtx[i]), 32'(etx[i]));
            chk("query_ty", 32'(rty[i]), 32'(ety[i]));
        end
        chk("ghost_x", 32'(ghost_x), 32'(m_x));
        chk("ghost_y", 32'(ghost_y), 32'(m_y));
        chk("cur_dir", 32'(cur_dir), 32'(m_dir));
        wall_ready = 1'b0;
        @(negedge Clk);
        chk("step_done_pulse", 32'(step_done), 32'd0);
    endtask

    initial begin
        int lat, n, nx, ny, tx, ty;
        bit blk;
        logic [7:0] codes[4];
        codes[0] = 8'h04; codes[1] = 8'h07; codes[2] = 8'h16; codes[3] = 8'h1A;

        // reset values
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_ghost_x", 32'(ghost_x), 32'd320);
        chk("rst_ghost_y", 32'(ghost_y), 32'd240);
        chk("rst_cur_dir", 32'(cur_dir), 32'd0);
        chk("rst_query_valid", 32'(query_valid), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // minimum latency right step
        do_step(8'h07, 0, 0, 0, lat);
        chk("latency_right", 32'(lat), 32'd1);

        // hit on new direction, fall back to committed right
        do_step(8'h1A, 1, 0, 1, lat);

        // walk to the left edge, then wrap
        n = 0;
        while (m_x != 0 && n < 400) begin do_step(8'h04, 0, 0, 1, lat); n++; end
        do_step(8'h04, 0, 0, 1, lat);

        // walk to the top, commit left, then up is pre-blocked and left is walled
        n = 0;
        while (m_y != 0 && n < 400) begin do_step(8'h1A, 0, 0, 1, lat); n++; end
        do_step(8'h04, 0, 0, 1, lat);
        do_step(8'h1A, 1, 0, 0, lat);

        // walk to the bottom; final down is pre-blocked with down committed
        n = 0;
        while (m_y + STEP + SIZE - 1 <= Y_MAX && n < 400) begin do_step(8'h16, 0, 0, 1, lat); n++; end
        do_step(8'h16, 0, 0, 1, lat);

        // random walk
        for (int i = 0; i < 80; i++) begin
            logic [7:0] code;
            n    = $urandom_range(0, 4);
            code = (n == 4) ? 8'($urandom) : codes[n];
            do_step(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, lat);
        end

        // stall with wall_ready low; a tick during the stall flags overrun only
        cand(1, m_x, m_y, blk, nx, ny, tx, ty);
        wall_ready = 1'b0;
        frame_tick = 1'b1;
        dir_in     = 8'h07;
        @(negedge Clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(query_valid), 32'd1);
            chk("stall_tx", 32'(query_tx), 32'(tx));
            chk("stall_ty", 32'(query_ty), 32'(ty));
            frame_tick = (i == 2);
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wall_ready = 1'b1;
        wall_hit   = 1'b0;
        @(negedge Clk);
        m_x   = nx;
        m_dir = 1;
        chk("stall_step_done", 32'(step_done), 32'd1);
        chk("stall_ghost_x", 32'(ghost_x), 32'(m_x));
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("no_second_step", 32'(query_valid | step_done), 32'd0);
        end
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("after_stall_x", 32'(ghost_x), 32'(m_x));
        wall_ready = 1'b0;

        // reset in the middle of a query
        frame_tick = 1'b1;
        dir_in     = 8'h07;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        chk("mid_query_valid", 32'(query_valid), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(query_valid), 32'd0);
        chk("abort_ghost_x", 32'(ghost_x), 32'd320);
        chk("abort_ghost_y", 32'(ghost_y), 32'd240);
        chk("abort_overrun", 32'(overrun), 32'd0);
        chk("abort_cur_dir", 32'(cur_dir), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        @(negedge Clk);
        do_step(8'h07, 0, 0, 0, lat);
        chk("fresh_latency", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
